clip_sample_timer: RTL and testbench

Timing and address generator answering the recorder controller's `timer` request. While a clip is recording or playing, it divides the system clock down to the audio sample rate and steps the clip memory address once per sample. After a full clip it returns a one-cycle `seconds2` pulse, which is the completion event the controller waits on to return to idle. It sits between the controller and the two clip memories.

---
 rtl/clip_sample_timer.sv | 245 ++++++++++++++++++++++++
 tb/tb_clip_sample_timer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/clip_sample_timer.sv
// clip_sample_timer
//
// Sample-rate timer and clip address generator for the recorder controller.
// While timer is held high it divides clock by DIV = CLK_HZ/SAMPLE_HZ,
// emits one sample_strobe per sample period and steps address through the
// clip. After the last sample it emits a single-cycle seconds2 pulse.
//
// Optional feature macro: CLIP_LEN_CAPTURE_EN
//   When defined, each clip keeps a length register. An aborted recording
//   stores the number of samples written, and playback of that clip stops
//   after that many samples.
//
// Ports
//   clock               in   system clock, rising edge
//   reset_n             in   asynchronous active-low reset
//   timer               in   run request, level-sensitive
//   memoryselect_clip_1 in   [1] write enable, [0] enable for clip 1
//   memoryselect_clip_2 in   [1] write enable, [0] enable for clip 2
//   seconds2            out  one-cycle clip-complete pulse
//   address             out  current sample index to both clip memories
//   sample_strobe       out  one-cycle pulse per sample period
//   write_strobe        out  sample_strobe qualified by the latched write mode
//   busy                out  high in RUN and DONE
//
// State | meaning
// ------+-----------------------------------------------------------------
// IDLE  | address and prescaler held at 0, waiting for timer = 1
// RUN   | prescaler running, one strobe and address step per sample
// DONE  | one cycle, seconds2 high
// HOLD  | clip finished, waiting for timer = 0 before a new run is allowed

module clip_sample_timer #(
   parameter int unsigned CLK_HZ       = 40_000_000,
   parameter int unsigned SAMPLE_HZ    = 8_000,
   parameter int unsigned CLIP_SECONDS = 2,
   parameter int unsigned ADDR_WIDTH   = 14
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  timer,
   input  logic [1:0]            memoryselect_clip_1,
   input  logic [1:0]            memoryselect_clip_2,
   output logic                  seconds2,
   output logic [ADDR_WIDTH-1:0] address,
   output logic                  sample_strobe,
   output logic                  write_strobe,
   output logic                  busy
);

   localparam int unsigned DIV     = CLK_HZ / SAMPLE_HZ;
   localparam int unsigned SAMPLES = SAMPLE_HZ * CLIP_SECONDS;
   localparam int unsigned PS_W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned LW      = ADDR_WIDTH + 1;

   localparam logic [PS_W-1:0] PS_LAST     = PS_W'(DIV - 1);
   localparam logic [LW-1:0]   LEN_SAMPLES = LW'(SAMPLES);

   localparam logic [1:0] CLIP_NONE = 2'd0;
   localparam logic [1:0] CLIP_1    = 2'd1;
   localparam logic [1:0] CLIP_2    = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE,
      S_HOLD
   } state_t;

   state_t                state_q,    state_d;
   logic [PS_W-1:0]       prescale_q, prescale_d;
   logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
   logic [1:0]            clip_q,     clip_d;
   logic                  wmode_q,    wmode_d;
   logic                  strobe_q,   strobe_d;
   logic                  wstrobe_q,  wstrobe_d;
   logic                  sec_q,      sec_d;
   logic                  busy_q,     busy_d;

   logic [LW-1:0]         end_len;
   logic                  last_sample;

`ifdef CLIP_LEN_CAPTURE_EN
   logic [LW-1:0]         len1_q, len1_d;
   logic [LW-1:0]         len2_q, len2_d;
   logic [LW-1:0]         wcnt_q, wcnt_d;

   // Recordings always run full length; only playback honours a stored length.
   always_comb begin
      end_len = LEN_SAMPLES;
      if (!wmode_q && clip_q == CLIP_1) begin
         end_len = len1_q;
      end else if (!wmode_q && clip_q == CLIP_2) begin
         end_len = len2_q;
      end
   end
`else
   assign end_len = LEN_SAMPLES;
`endif

   assign last_sample = ({1'b0, addr_q} == (end_len - LW'(1)));

   always_comb begin
      state_d    = state_q;
      prescale_d = prescale_q;
      addr_d     = addr_q;
      clip_d     = clip_q;
      wmode_d    = wmode_q;
`ifdef CLIP_LEN_CAPTURE_EN
      len1_d     = len1_q;
      len2_d     = len2_q;
      wcnt_d     = wcnt_q;
`endif

      unique case (state_q)
         S_IDLE: begin
            prescale_d = '0;
            addr_d     = '0;
`ifdef CLIP_LEN_CAPTURE_EN
            wcnt_d     = '0;
`endif
            if (timer) begin
               state_d = S_RUN;
               if (memoryselect_clip_1[0]) begin
                  clip_d  = CLIP_1;
                  wmode_d = memoryselect_clip_1[1];
               end else if (memoryselect_clip_2[0]) begin
                  clip_d  = CLIP_2;
                  wmode_d = memoryselect_clip_2[1];
               end else begin
                  clip_d  = CLIP_NONE;
                  wmode_d = 1'b0;
               end
            end
         end

         S_RUN: begin
`ifdef CLIP_LEN_CAPTURE_EN
            // Counts strobes already emitted; the one in flight is added on abort.
            wcnt_d = wcnt_q + LW'(wstrobe_q);
`endif
            if (!timer) begin
               state_d    = S_IDLE;
               prescale_d = '0;
               addr_d     = '0;
`ifdef CLIP_LEN_CAPTURE_EN
               if (wmode_q && clip_q == CLIP_1) len1_d = wcnt_q + LW'(wstrobe_q);
               if (wmode_q && clip_q == CLIP_2) len2_d = wcnt_q + LW'(wstrobe_q);
`endif
            end else if (end_len == '0) begin
               state_d    = S_DONE;
               prescale_d = '0;
            end else if (prescale_q == PS_LAST) begin
               prescale_d = '0;
               if (last_sample) begin
                  state_d = S_DONE;
`ifdef CLIP_LEN_CAPTURE_EN
                  if (wmode_q && clip_q == CLIP_1) len1_d = LEN_SAMPLES;
                  if (wmode_q && clip_q == CLIP_2) len2_d = LEN_SAMPLES;
`endif
               end else begin
                  addr_d = addr_q + ADDR_WIDTH'(1);
               end
            end else begin
               prescale_d = prescale_q + PS_W'(1);
            end
         end

         S_DONE: begin
            prescale_d = '0;
            if (timer) begin
               state_d = S_HOLD;
            end else begin
               state_d = S_IDLE;
               addr_d  = '0;
            end
         end

         S_HOLD: begin
            prescale_d = '0;
            if (!timer) begin
               state_d = S_IDLE;
               addr_d  = '0;
            end
         end

         default: begin
            state_d    = S_IDLE;
            prescale_d = '0;
            addr_d     = '0;
         end
      endcase

      // Outputs are derived from next-state values so they are registered
      // yet line up with the cycle they describe.
      strobe_d  = (state_d == S_RUN) && (prescale_d == PS_LAST);
      wstrobe_d = strobe_d && wmode_d;
      sec_d     = (state_d == S_DONE);
      busy_d    = (state_d == S_RUN) || (state_d == S_DONE);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         prescale_q <= '0;
         addr_q     <= '0;
         clip_q     <= CLIP_NONE;
         wmode_q    <= 1'b0;
         strobe_q   <= 1'b0;
         wstrobe_q  <= 1'b0;
         sec_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         prescale_q <= prescale_d;
         addr_q     <= addr_d;
         clip_q     <= clip_d;
         wmode_q    <= wmode_d;
         strobe_q   <= strobe_d;
         wstrobe_q  <= wstrobe_d;
         sec_q      <= sec_d;
         busy_q     <= busy_d;
      end
   end

`ifdef CLIP_LEN_CAPTURE_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         len1_q <= LEN_SAMPLES;
         len2_q <= LEN_SAMPLES;
         wcnt_q <= '0;
      end else begin
         len1_q <= len1_d;
         len2_q <= len2_d;
         wcnt_q <= wcnt_d;
      end
   end
`endif

   assign seconds2      = sec_q;
   assign address       = addr_q;
   assign sample_strobe = strobe_q;
   assign write_strobe  = wstrobe_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_clip_sample_timer.sv
module tb_clip_sample_timer;

   localparam int DIV     = 10;
   localparam int SAMPLES = 8;
   localparam int AW      = 14;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          timer;
   logic [1:0]    msel1;
   logic [1:0]    msel2;
   logic          seconds2;
   logic [AW-1:0] address;
   logic          sample_strobe;
   logic          write_strobe;
   logic          busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int cyc;
      int adr;
      bit wr;
   } exp_t;

   exp_t sb[$];

   clip_sample_timer #(
      .CLK_HZ      (40),
      .SAMPLE_HZ   (4),
      .CLIP_SECONDS(2),
      .ADDR_WIDTH  (AW)
   ) dut (
      .clock              (clk),
      .reset_n            (rst_n),
      .timer              (timer),
      .memoryselect_clip_1(msel1),
      .memoryselect_clip_2(msel2),
      .seconds2           (seconds2),
      .address            (address),
      .sample_strobe      (sample_strobe),
      .write_strobe       (write_strobe),
      .busy               (busy)
   );

   always #5 clk = ~clk;

   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string name);
      checks++;
      if ({seconds2, address, sample_strobe, write_strobe, busy} !== '0) begin
         errors++;
         $display("FAIL %s: s2=%b addr=%0d strobe=%b wstrobe=%b busy=%b, required all 0",
                  name, seconds2, address, sample_strobe, write_strobe, busy);
      end
   endtask

   // One run: n_exp strobes expected (at cycles DIV*(i+1)), optional abort
   // (timer low during cycle abort_cyc), optional extra cycles of timer high
   // after seconds2.
   task automatic do_run(input logic [1:0] m1, input logic [1:0] m2, input int n_exp,
                         input bit wr, input int abort_cyc, input int hold_extra,
                         input string name);
      exp_t e;
      int   sec_cyc;
      int   last_cyc;
      int   sec_seen;
      sec_cyc  = (n_exp > 0) ? n_exp * DIV + 1 : 2;
      last_cyc = (abort_cyc != 0) ? abort_cyc + 1 : sec_cyc + hold_extra;
      sec_seen = 0;
      sb.delete();
      for (int i = 0; i < n_exp; i++) begin
         e.cyc = DIV * (i + 1);
         e.adr = i;
         e.wr  = wr;
         sb.push_back(e);
      end
      msel1 = m1;
      msel2 = m2;
      timer = 1'b1;
      for (int k = 1; k <= last_cyc; k++) begin
         next_cycle();
         if (k == 1) begin
            // Selections after the mode is latched must have no effect.
            msel1 = 2'b00;
            msel2 = 2'b00;
            checks++;
            if (busy !== 1'b1) begin
               errors++;
               $display("FAIL %s busy_start: got %b, required 1", name, busy);
            end
         end
         if (sample_strobe === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL %s extra_strobe: strobe at cycle %0d addr %0d, required none", name, k, address);
            end else begin
               e = sb.pop_front();
               if (k !== e.cyc || address !== AW'(e.adr) || write_strobe !== e.wr) begin
                  errors++;
                  $display("FAIL %s strobe: cycle %0d addr %0d wr %b, required cycle %0d addr %0d wr %b",
                           name, k, address, write_strobe, e.cyc, e.adr, e.wr);
               end
            end
         end else if (write_strobe !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL %s wstrobe_alone: write_strobe=%b at cycle %0d without sample_strobe", name, write_strobe, k);
         end
         if (seconds2 === 1'b1) begin
            sec_seen++;
            checks++;
            if (abort_cyc != 0 || k != sec_cyc) begin
               errors++;
               $display("FAIL %s seconds2: pulse at cycle %0d, required %0d", name, k,
                        (abort_cyc != 0) ? -1 : sec_cyc);
            end
         end
         if (hold_extra > 0 && k > sec_cyc) begin
            checks++;
            if (busy !== 1'b0 || seconds2 !== 1'b0) begin
               errors++;
               $display("FAIL %s hold: busy=%b s2=%b at cycle %0d, required 0 0", name, busy, seconds2, k);
            end
         end
         if (abort_cyc != 0 && k == abort_cyc + 1) begin
            checks++;
            if (address !== '0 || busy !== 1'b0) begin
               errors++;
               $display("FAIL %s abort_idle: addr=%0d busy=%b, required 0 0", name, address, busy);
            end
         end
         if (k == last_cyc - ((abort_cyc != 0) ? 1 : 0)) timer = 1'b0;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s missing_strobes: %0d outstanding, required 0", name, sb.size());
      end
      checks++;
      if (sec_seen != ((abort_cyc != 0) ? 0 : 1)) begin
         errors++;
         $display("FAIL %s seconds2_count: got %0d, required %0d", name, sec_seen, (abort_cyc != 0) ? 0 : 1);
      end
      next_cycle();
      next_cycle();
      check_all_zero({name, "_idle"});
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      timer = 1'b0;
      msel1 = 2'b00;
      msel2 = 2'b00;
      #1;
      check_all_zero("reset");
      repeat (3) next_cycle();
      rst_n = 1'b1;
      for (int i = 0; i < 50; i++) begin
         next_cycle();
         check_all_zero("reset_idle");
      end
   endtask

   task automatic test_full_record();
      do_run(2'b11, 2'b00, SAMPLES, 1'b1, 0, 5, "full_record");
   endtask

   task automatic test_playback();
      do_run(2'b00, 2'b01, SAMPLES, 1'b0, 0, 0, "playback");
      do_run(2'b00, 2'b00, SAMPLES, 1'b0, 0, 0, "no_clip");
      do_run(2'b01, 2'b11, SAMPLES, 1'b0, 0, 0, "priority");
   endtask

   task automatic test_abort();
      do_run(2'b00, 2'b11, 3, 1'b1, 35, 0, "abort");
      do_run(2'b00, 2'b11, 2, 1'b1, 20, 0, "abort_on_strobe");
   endtask

   task automatic test_midrun_reset();
      msel2 = 2'b01;
      timer = 1'b1;
      for (int k = 1; k <= 47; k++) next_cycle();
      checks++;
      if (busy !== 1'b1 || address !== AW'(4)) begin
         errors++;
         $display("FAIL midrun_pre: busy=%b addr=%0d, required 1 4", busy, address);
      end
      rst_n = 1'b0;
      #1;
      check_all_zero("midrun_reset");
      timer = 1'b0;
      msel2 = 2'b00;
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
      do_run(2'b00, 2'b01, SAMPLES, 1'b0, 0, 0, "restart");
   endtask

   task automatic test_len_capture();
      do_run(2'b11, 2'b00, 3, 1'b1, 35, 0, "cap_record");
`ifdef CLIP_LEN_CAPTURE_EN
      do_run(2'b01, 2'b00, 3, 1'b0, 0, 0, "cap_play1");
`else
      do_run(2'b01, 2'b00, SAMPLES, 1'b0, 0, 0, "cap_play1");
`endif
      do_run(2'b00, 2'b01, SAMPLES, 1'b0, 0, 0, "cap_play2");
      do_run(2'b11, 2'b00, 0, 1'b1, 5, 0, "cap_record_zero");
`ifdef CLIP_LEN_CAPTURE_EN
      do_run(2'b01, 2'b00, 0, 1'b0, 0, 0, "cap_play_zero");
`else
      do_run(2'b01, 2'b00, SAMPLES, 1'b0, 0, 0, "cap_play_zero");
`endif
      do_run(2'b11, 2'b00, SAMPLES, 1'b1, 0, 0, "cap_rerecord");
      do_run(2'b01, 2'b00, SAMPLES, 1'b0, 0, 0, "cap_play_full");
   endtask

   initial begin
      test_reset();
      test_full_record();
      test_playback();
      test_abort();
      test_midrun_reset();
      test_len_capture();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
